muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL support any even value >= 8.
REQ-002 clk  in  1  single clock; every register SHALL update on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 InValid  in  1  request valid.
REQ-005 InReady  out  1  unit can accept a request.
REQ-006 MDControl  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SrcA  in  XLEN  operand A (multiplicand/dividend).
REQ-008 SrcB  in  XLEN  operand B (multiplier/divisor).
REQ-009 Flush  in  1  abandon any request in flight.
REQ-010 OutValid  out  1  MDResult valid.
REQ-011 OutReady  in  1  consumer accepts result.
REQ-012 MDResult  out  XLEN  result.

Function
REQ-013 FSM states IDLE, CALC, DONE; InReady SHALL be 1 only in IDLE; OutValid SHALL be 1 only in DONE.
REQ-014 Accept on a cycle with IDLE & InValid & !Flush; SrcA, SrcB and MDControl SHALL be captured that edge and ignored afterwards.
REQ-015 Normal accept -> CALC; a counter SHALL run exactly XLEN cycles (one shift-add or restoring-subtract step per cycle), then -> DONE; OutValid first high XLEN+1 cycles after the accept edge.
REQ-016 Special divide cases SHALL bypass CALC (IDLE -> DONE, OutValid on the next cycle): divisor 0 -> DIV/DIVU result all-ones, REM/REMU result = SrcA; signed DIV/REM with SrcA = 2^(XLEN-1) and SrcB = -1 -> DIV result 2^(XLEN-1), REM result 0.
REQ-017 Signed ops SHALL run on magnitudes; the final sign SHALL be applied in the transition to DONE. Quotient sign = signA XOR signB; remainder sign = sign of dividend. MULHSU treats only A as signed.
REQ-018 MUL SHALL return product bits [XLEN-1:0]; MULH/MULHSU/MULHU SHALL return bits [2*XLEN-1:XLEN] of the 2*XLEN-bit product.
REQ-019 DONE SHALL hold MDResult stable until OutValid & OutReady, then -> IDLE; no new request SHALL be accepted in that same cycle.
REQ-020 Flush high in CALC or DONE SHALL force IDLE on the next edge with no OutValid pulse; Flush has priority over OutReady and over accept.
REQ-021 MDResult SHALL be 0 whenever OutValid is 0.

Reset
REQ-022 rst SHALL force IDLE, counter 0 and all datapath registers 0 on the next edge, in any state including mid-CALC; the in-flight request is dropped.
REQ-023 While rst is high: InReady 0, OutValid 0, MDResult 0; InReady SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-024 A shared package SHALL hold the MDControl opcode constants and the FSM state encoding; the ALU decoder and this unit SHALL both use it.
REQ-025 A single sub-module, muldiv_step, SHALL implement one combinational iteration (add-shift or restore-subtract) of width XLEN+1; the top level holds the FSM, counter and sign handling.
REQ-026 Expected RTL size 120-400 lines; no vendor multiplier/divider primitives.

Verification (XLEN=32)
REQ-027 MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB at cycle 33 after accept; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-028 DIV 20 / 0xFFFFFFFD -> 0xFFFFFFFA; REM same operands -> 2; REM 0xFFFFFFEC / 3 -> 0xFFFFFFFE.
REQ-029 DIVU 0x1234 / 0 -> 0xFFFFFFFF, REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; all with OutValid one cycle after accept.
REQ-030 OutReady held low 5 cycles in DONE -> MDResult constant, InReady 0 throughout; handshake -> IDLE next cycle, InReady 1.
REQ-031 Flush at CALC cycle 10 -> IDLE next edge, no OutValid ever; a new request accepted the following cycle completes correctly.
REQ-032 rst asserted at CALC cycle 20 -> outputs 0 next edge; after release, DIVU 100 / 7 -> 14 with standard latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: MDControl opcodes,
// FSM state encoding and small opcode-classification helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // Divide-family opcodes all have the top bit set.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Operand A is interpreted as two's complement.
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is interpreted as two's complement (MULHSU treats B as unsigned).
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider on unsigned magnitudes.
// Multiply: shift-add of {hi,lo}, multiplier in lo, multiplicand in operand.
// Divide: restoring subtract, partial remainder in hi, dividend/quotient in lo.
// The add/subtract is XLEN+1 bits wide so carry and borrow are kept.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] addend;
  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Compute both candidate iterations and select by operation class
  always_comb begin
    addend  = lo_in[0] ? {1'b0, operand} : '0;
    sum     = {1'b0, hi_in} + addend;
    shifted = {hi_in, lo_in[XLEN-1]};
    diff    = shifted - {1'b0, operand};
    hi_out  = '0;
    lo_out  = '0;
    if (is_div) begin
      // A clear top bit means the divisor fit: keep the difference, quotient bit 1.
      if (!diff[XLEN]) begin
        hi_out = diff[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b1};
      end else begin
        hi_out = shifted[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_out = sum[XLEN:1];
      lo_out = {sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V style M-extension unit: one bit per cycle for
// multiply and divide, with valid/ready handshakes on both sides.
// Signed operations run on magnitudes; the sign is applied when the
// final iteration is written into the result register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            InValid,
  output logic            InReady,
  input  logic [2:0]      MDControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] MDResult
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  md_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_r;
  logic            neg_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic [XLEN-1:0] opnd_r;
  logic [XLEN-1:0] result_r;

  logic [XLEN-1:0] hi_nx;
  logic [XLEN-1:0] lo_nx;

  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            neg_in;
  logic            special;
  logic [XLEN-1:0] special_res;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   final_res;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op_is_div(op_r)),
    .hi_in   (hi_r),
    .lo_in   (lo_r),
    .operand (opnd_r),
    .hi_out  (hi_nx),
    .lo_out  (lo_nx)
  );

  // Decode the incoming request: operand magnitudes, result sign, divide corner cases
  always_comb begin
    sign_a      = op_a_signed(MDControl) & SrcA[XLEN-1];
    sign_b      = op_b_signed(MDControl) & SrcB[XLEN-1];
    mag_a       = cond_neg(SrcA, sign_a);
    mag_b       = cond_neg(SrcB, sign_b);
    // Remainder takes the dividend's sign; products and quotients take the XOR.
    neg_in      = (MDControl == OP_REM) ? sign_a : (sign_a ^ sign_b);
    special     = 1'b0;
    special_res = '0;
    if (op_is_div(MDControl)) begin
      if (SrcB == '0) begin
        special     = 1'b1;
        special_res = MDControl[1] ? SrcA : '1;
      end else if (!MDControl[0] && (SrcA == INT_MIN) && (SrcB == '1)) begin
        special     = 1'b1;
        special_res = MDControl[1] ? '0 : INT_MIN;
      end
    end
  end

  // Form the signed result from the last iteration's outputs
  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = neg_r ? -prod : prod;
    if (op_is_div(op_r)) begin
      final_res = op_r[1] ? cond_neg(hi_nx, neg_r) : cond_neg(lo_nx, neg_r);
    end else if (op_r == OP_MUL) begin
      final_res = prod_s[XLEN-1:0];
    end else begin
      final_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Control FSM with iteration counter and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_r     <= '0;
      neg_r    <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      opnd_r   <= '0;
      result_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (InValid && !Flush) begin
            op_r  <= MDControl;
            neg_r <= neg_in;
            cnt   <= '0;
            if (special) begin
              result_r <= special_res;
              state    <= DONE;
            end else begin
              hi_r   <= '0;
              lo_r   <= op_is_div(MDControl) ? mag_a : mag_b;
              opnd_r <= op_is_div(MDControl) ? mag_b : mag_a;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          if (Flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            hi_r <= hi_nx;
            lo_r <= lo_nx;
            if (cnt == CNT_LAST) begin
              result_r <= final_res;
              cnt      <= '0;
              state    <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          // Flush and a completed handshake both retire the result.
          if (Flush || OutReady) begin
            result_r <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign InReady  = (state == IDLE) && !rst;
  assign OutValid = (state == DONE) && !rst;
  assign MDResult = OutValid ? result_r : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32 with hand-computed results.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic [2:0]  MDControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Flush;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] MDResult;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .InValid   (InValid),
    .InReady   (InReady),
    .MDControl (MDControl),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Flush     (Flush),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .MDResult  (MDResult)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request from a negedge in IDLE, scramble inputs after the
  // accept edge, and measure the cycle at which OutValid first appears.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    InValid = 1'b1; MDControl = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    InValid = 1'b0; MDControl = 3'b111; SrcA = 32'hDEADBEEF; SrcB = 32'h0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (OutValid) begin
        lat = c;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, MDResult, exp);
    if (OutReady) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; InValid = 1'b0; MDControl = 3'b000; SrcA = '0; SrcB = '0;
    Flush = 1'b0; OutReady = 1'b1;

    // Reset behaviour
    repeat (3) @(negedge clk);
    check("rst_inready", {31'b0, InReady}, 32'd0);
    check("rst_outvalid", {31'b0, OutValid}, 32'd0);
    check("rst_result", MDResult, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_inready", {31'b0, InReady}, 32'd1);
    @(negedge clk);

    // Multiply family
    run_op("mul_7xm3",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mul_shift",   OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33);
    run_op("mulh_min",    OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu_max",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu_neg",  OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);

    // Divide family
    run_op("div_20_m3",   OP_DIV,    32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    run_op("rem_20_m3",   OP_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        33);
    run_op("rem_m20_3",   OP_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, 33);
    run_op("divu_max_1",  OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33);
    run_op("remu_100_7",  OP_REMU,   32'd100,      32'd7,        32'd2,        33);

    // Special cases bypass the iteration
    run_op("divu_by0",    OP_DIVU,   32'h1234,     32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_by0",    OP_REMU,   32'h1234,     32'd0,        32'h00001234, 1);
    run_op("div_ovf",     OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",     OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("div_by0",     OP_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1);

    // Back-pressure: result held while OutReady is low
    OutReady = 1'b0;
    run_op("bp_mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_res", MDResult, 32'hFFFFFFFE);
      check("bp_hold_inready", {31'b0, InReady}, 32'd0);
      check("bp_hold_valid", {31'b0, OutValid}, 32'd1);
      @(negedge clk);
    end
    OutReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_done_valid", {31'b0, OutValid}, 32'd0);
    check("bp_done_inready", {31'b0, InReady}, 32'd1);

    // Flush in DONE together with OutReady
    OutReady = 1'b0;
    run_op("fl_done_div", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    Flush = 1'b1; OutReady = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    @(negedge clk);
    check("fl_done_valid", {31'b0, OutValid}, 32'd0);
    check("fl_done_result", MDResult, 32'd0);
    check("fl_done_inready", {31'b0, InReady}, 32'd1);

    // Flush blocks an accept in IDLE
    InValid = 1'b1; Flush = 1'b1; MDControl = OP_DIVU; SrcA = 32'd5; SrcB = 32'd0;
    @(posedge clk); #1;
    InValid = 1'b0; Flush = 1'b0;
    @(negedge clk);
    check("fl_idle_valid", {31'b0, OutValid}, 32'd0);
    check("fl_idle_inready", {31'b0, InReady}, 32'd1);

    // Flush at CALC cycle 10, then a fresh request right away
    InValid = 1'b1; MDControl = OP_MUL; SrcA = 32'd3; SrcB = 32'd5;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (10) @(negedge clk);
    check("fl_calc_inready", {31'b0, InReady}, 32'd0);
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    @(negedge clk);
    check("fl_calc_inready_after", {31'b0, InReady}, 32'd1);
    check("fl_calc_valid_after", {31'b0, OutValid}, 32'd0);
    run_op("after_flush", OP_MUL, 32'd6, 32'd9, 32'd54, 33);

    // Reset at CALC cycle 20, then a normal divide
    InValid = 1'b1; MDControl = OP_DIV; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", {31'b0, OutValid}, 32'd0);
    check("mid_rst_result", MDResult, 32'd0);
    check("mid_rst_inready", {31'b0, InReady}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_release_inready", {31'b0, InReady}, 32'd1);
    @(negedge clk);
    run_op("after_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
